// File: rtl/imm_encoder_if.sv
// Handshake and payload bundle for the immediate encoder: input item side and result side.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_type, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_type, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage pipelined immediate encoder: scatters a 32-bit immediate into the
// B/I/S/U/J bit positions of a base instruction, flagging unrepresentable values.
module imm_encoder #(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  imm_encoder_if.slave         bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] TYPE_B = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_U = 3'd3;
  localparam logic [2:0] TYPE_J = 3'd4;

  logic        s1_valid;
  logic [2:0]  s1_type;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;

  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_err;

  logic        s2_load;
  logic        accept;
  logic        out_xfer;
  logic [31:0] enc_instr;
  logic        enc_err;

  assign s2_load      = !s2_valid || bus.out_ready;
  assign bus.in_ready = rst_n && !flush && (!s1_valid || s2_load);
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_xfer     = s2_valid && bus.out_ready;

  assign bus.out_valid = s2_valid;
  assign bus.out_instr = s2_instr;
  assign bus.out_err   = s2_err;

  // Placement and range check for the item held in S1; errored items keep the truncated placement.
  always_comb begin
    enc_instr = s1_base;
    enc_err   = 1'b0;
    case (s1_type)
      TYPE_I: begin
        enc_instr = {s1_imm[11:0], s1_base[19:0]};
        enc_err   = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      end
      TYPE_S: begin
        enc_instr = {s1_imm[11:5], s1_base[24:12], s1_imm[4:0], s1_base[6:0]};
        enc_err   = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      end
      TYPE_B: begin
        enc_instr = {s1_imm[12], s1_imm[10:5], s1_base[24:12], s1_imm[4:1],
                     s1_imm[11], s1_base[6:0]};
        enc_err   = s1_imm[0] || !((&s1_imm[31:12]) || !(|s1_imm[31:12]));
      end
      TYPE_U: begin
        enc_instr = {s1_imm[31:12], s1_base[11:0]};
        enc_err   = |s1_imm[11:0];
      end
      TYPE_J: begin
        enc_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_base[11:0]};
        enc_err   = s1_imm[0] || !((&s1_imm[31:20]) || !(|s1_imm[31:20]));
      end
      default: begin
        enc_instr = s1_base;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Pipeline registers and saturating error counter; flush drops both stages without counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_type   <= 3'd0;
      s1_imm    <= 32'd0;
      s1_base   <= 32'd0;
      s2_valid  <= 1'b0;
      s2_instr  <= 32'd0;
      s2_err    <= 1'b0;
      err_count <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (out_xfer && s2_err && !(&err_count)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_instr <= enc_instr;
          s2_err   <= enc_err;
        end
      end
      if (accept) begin
        s1_valid <= 1'b1;
        s1_type  <= bus.in_type;
        s1_imm   <= bus.in_imm;
        s1_base  <= bus.in_base;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vector table, stall/flush/reset
// sequences, a random handshake run checked by decode-back, and counter saturation.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] err_count;

  imm_encoder_if bus ();

  imm_encoder #(.ERR_CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic void bump_cnt();
    if (exp_cnt < 65535) exp_cnt++;
  endfunction

  // Representability by signed range, independent of bit-slicing.
  function automatic logic model_err(input logic [2:0] t, input logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (t)
      3'd1, 3'd2: return !(v >= -2048 && v <= 2047);
      3'd0:       return imm[0] || !(v >= -4096 && v <= 4094);
      3'd4:       return imm[0] || !(v >= -1048576 && v <= 1048574);
      3'd3:       return (imm % 32'd4096) != 32'd0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] decode(input logic [2:0] t, input logic [31:0] x);
    case (t)
      3'd1:    return {{20{x[31]}}, x[31:20]};
      3'd2:    return {{20{x[31]}}, x[31:25], x[11:7]};
      3'd0:    return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      3'd3:    return {x[31:12], 12'd0};
      3'd4:    return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] imm_mask(input logic [2:0] t);
    case (t)
      3'd1:       return 32'hFFF0_0000;
      3'd0, 3'd2: return 32'hFE00_0F80;
      3'd3, 3'd4: return 32'hFFFF_F000;
      default:    return 32'h0000_0000;
    endcase
  endfunction

  task automatic check_result(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base,
                              input logic [31:0] instr, input logic err);
    logic e;
    e = model_err(t, imm);
    chk("res_err", 32'(err), 32'(e));
    chk("res_base_bits", instr & ~imm_mask(t), base & ~imm_mask(t));
    if (!e) chk("res_decode", decode(t, instr), imm);
  endtask

  // One isolated item: checks acceptance, two-edge latency, result and counter.
  task automatic run_one(input int idx);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_type   = vecs[idx].t;
    bus.in_imm    = vecs[idx].imm;
    bus.in_base   = vecs[idx].base;
    bus.out_ready = 1'b1;
    #1 chk($sformatf("vec%0d_in_ready", idx), 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk($sformatf("vec%0d_early_valid", idx), 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk($sformatf("vec%0d_out_valid", idx), 32'(bus.out_valid), 32'd1);
    chk($sformatf("vec%0d_instr", idx), bus.out_instr, vecs[idx].instr);
    chk($sformatf("vec%0d_err", idx), 32'(bus.out_err), 32'(vecs[idx].err));
    @(negedge clk);
    if (vecs[idx].err) bump_cnt();
    chk($sformatf("vec%0d_drained", idx), 32'(bus.out_valid), 32'd0);
    chk($sformatf("vec%0d_err_count", idx), 32'(err_count), 32'(exp_cnt));
  endtask

  // Streams n items under a fixed mid-stream stall (rnd=0) or random valid/ready (rnd=1).
  task automatic stream(input int n, input bit rnd);
    int acc = 0;
    int got = 0;
    int budget;
    bit held_v = 1'b0;
    bit saw_full = 1'b0;
    logic [31:0] held_i;
    logic        held_e;
    logic [2:0]  qt[$];
    logic [31:0] qi[$];
    logic [31:0] qb[$];
    int r;
    budget = n * 10 + 50;
    for (int cyc = 0; cyc < budget && got < n; cyc++) begin
      @(negedge clk);
      if (acc < n) begin
        if (rnd) begin
          bus.in_valid = ($urandom_range(0, 3) != 0);
          r = $urandom_range(0, 9);
          bus.in_type = (r < 8) ? 3'(r % 5) : 3'(r - 3);
          case ($urandom_range(0, 3))
            0:       bus.in_imm = $urandom;
            1:       bus.in_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            2:       bus.in_imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
            default: bus.in_imm = $urandom << 12;
          endcase
          bus.in_base = $urandom;
        end else begin
          bus.in_valid = 1'b1;
          bus.in_type  = 3'd1;
          bus.in_imm   = 32'(acc + 1);
          bus.in_base  = 32'h0000_0013;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 3 && cyc < 7);
      #1;
      if (held_v) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_instr", bus.out_instr, held_i);
        chk("stall_err", 32'(bus.out_err), 32'(held_e));
      end
      chk("in_ready_model", 32'(bus.in_ready), 32'((acc - got < 2) || bus.out_ready));
      if (!bus.in_ready) saw_full = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        if (qt.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          check_result(qt.pop_front(), qi.pop_front(), qb.pop_front(), bus.out_instr, bus.out_err);
          if (bus.out_err) bump_cnt();
        end
        got++;
      end
      held_v = bus.out_valid && !bus.out_ready;
      held_i = bus.out_instr;
      held_e = bus.out_err;
      if (bus.in_valid && bus.in_ready) begin
        qt.push_back(bus.in_type);
        qi.push_back(bus.in_imm);
        qb.push_back(bus.in_base);
        acc++;
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("stream_count", 32'(got), 32'(n));
    chk("stream_err_count", 32'(err_count), 32'(exp_cnt));
    if (!rnd) chk("stall_in_ready_low", 32'(saw_full), 32'd1);
  endtask

  // Loads two items with the output stalled so both stages are occupied.
  task automatic fill2(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_type   = t;
    bus.in_imm    = imm;
    bus.in_base   = base;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("fill_out_valid", 32'(bus.out_valid), 32'd1);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0};
    vecs[1]  = '{3'd0, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0};
    vecs[2]  = '{3'd0, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1};
    vecs[3]  = '{3'd0, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 1'b1};
    vecs[4]  = '{3'd3, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0};
    vecs[5]  = '{3'd3, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1};
    vecs[6]  = '{3'd7, 32'h1234_5000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[7]  = '{3'd4, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0};
    vecs[8]  = '{3'd2, 32'hFFFF_F800, 32'h0000_0023, 32'h8000_0023, 1'b0};
    vecs[9]  = '{3'd2, 32'h0000_0800, 32'h0000_0023, 32'h8000_0023, 1'b1};
    vecs[10] = '{3'd1, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0};
    vecs[11] = '{3'd1, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1};
    vecs[12] = '{3'd4, 32'h0000_0001, 32'h0000_006F, 32'h0000_006F, 1'b1};
    vecs[13] = '{3'd4, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1};
    vecs[14] = '{3'd4, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0};
    vecs[15] = '{3'd0, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_type   = 3'd0;
    bus.in_imm    = 32'd0;
    bus.in_base   = 32'd0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_one(i);

    stream(5, 1'b0);
    stream(60, 1'b1);

    // Flush with both stages full and a new item offered
    fill2(3'd1, 32'h0000_0800, 32'h0000_0013);
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("flush_no_accept", 32'(bus.out_valid), 32'd0);
    chk("flush_err_count", 32'(err_count), 32'(exp_cnt));

    // Reset mid-stream
    fill2(3'd7, 32'd0, 32'hFFFF_FFFF);
    rst_n = 1'b0;
    #1 chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_instr", bus.out_instr, 32'd0);
    chk("midrst_out_err", 32'(bus.out_err), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    exp_cnt = 0;
    rst_n = 1'b1;

    // Saturation: 2^16+3 errored results back to back
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_type   = 3'd7;
    bus.in_base   = 32'h0000_0000;
    repeat (65539) @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_err_count", 32'(err_count), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
